alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_op  in  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL, 101-111 illegal.
REQ-008 req_a, req_b  in  32 each  operands.
REQ-009 alu_inA, alu_inB  out  32 each  operands driven to the combinational ALU.
REQ-010 alu_Ctrl  out  3  ALU control, same encoding as req_op.
REQ-011 alu_result  in  32  ALU result.
REQ-012 alu_zero, alu_overflow, alu_Cout  in  1 each  ALU flags.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts the response.
REQ-015 rsp_result  out  32  result.
REQ-016 rsp_zero, rsp_overflow, rsp_cout, rsp_err  out  1 each  flags; rsp_err marks an illegal opcode.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, MUL, RESP; req_ready=1 only in IDLE.
REQ-018 Accept occurs at an edge where the FSM is in IDLE and req_valid=1; op, a and b are latched at that edge.
REQ-019 After an accept, ops 000-011 go to EXEC, 100 goes to MUL, and 101-111 go to RESP with result=0, zero=0, overflow=0, cout=0, err=1.
REQ-020 EXEC lasts one cycle, driving alu_inA=a, alu_inB=b, alu_Ctrl=op; at its end edge, alu_result and the three flags are registered into the rsp_* outputs, err=0, and the FSM enters RESP.
REQ-021 MUL is shift-add over exactly 32 cycles.
- Initial values: acc=0, mcand=a, mplier=b.
- Each cycle: drive alu_inA=acc, alu_inB=mcand, alu_Ctrl=000.
- At each edge: if mplier[0]=1, acc<=alu_result; always mcand<<=1 (logical) and mplier>>=1 (logical).
REQ-022 After the 32nd MUL edge, rsp_result=acc (low 32 product bits, mod 2^32), rsp_zero=(acc==0), overflow=0, cout=0, err=0, and the FSM enters RESP.
REQ-023 MUL flags SHALL be computed locally; the ALU flags are ignored during MUL.
REQ-024 Latency from accept edge to rsp_valid=1: 1 edge for ops 000-011, 32 edges for MUL, 0 edges for illegal ops (rsp_valid rises after the accept edge itself).
REQ-025 In RESP, rsp_valid=1 and all rsp_* outputs SHALL stay stable until an edge with rsp_ready=1, then the FSM returns to IDLE.
REQ-026 req_ready is 0 in RESP, so back-to-back throughput is at most one op per 3 cycles for ops 000-011.
REQ-027 When not in EXEC or MUL, alu_inA, alu_inB and alu_Ctrl SHALL be 0.
REQ-028 req_valid or operand changes while req_ready=0 SHALL have no effect.

Reset
REQ-029 While reset=1 at an edge, the FSM goes to IDLE, and req_ready becomes 1 after that edge.
REQ-030 Reset values: rsp_valid=0, rsp_result=0, all rsp flags=0, alu_inA=alu_inB=alu_Ctrl=0, acc=mcand=mplier=0, MUL counter=0.
REQ-031 Reset SHALL override any in-progress EXEC, MUL or RESP; a pending response is discarded and not presented after reset.
REQ-032 Reset has priority over a simultaneous accept; the request is not latched.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=1, ALU model returns overflow=1 -> rsp after 1 edge: result=0x80000000, overflow=1, zero=0, err=0.
REQ-034 SUB a=5, b=5 -> result=0, zero=1; rsp held 3 cycles with rsp_ready=0, outputs unchanged and req_ready=0 throughout.
REQ-035 MUL a=0x00010001, b=0x00010001 -> rsp_valid exactly 32 edges after accept, result=0x00020001, zero=0, overflow=0.
REQ-036 MUL a=0x80000000, b=2 -> result=0, zero=1; also MUL by 0 -> result=0, zero=1.
REQ-037 Illegal op 110 -> rsp_valid after 0 edges, err=1, result=0; then req_ready=1 on the cycle after the rsp_ready edge.
REQ-038 Reset asserted at MUL iteration 10 -> IDLE next edge, rsp_valid=0, alu_* outputs=0; a following XOR a=0xF0F0F0F0, b=0xFFFF0000 returns 0x0F0FF0F0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences single ALU ops and a 32-step shift-add multiply through an external combinational ALU.
// Latency: 1 edge for ADD/SUB/XOR/SLT, 32 for MUL, 0 for illegal ops. The response is held until rsp_ready.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [2:0]       alu_Ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_Cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_cout,
  output logic             rsp_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    mulCnt;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] mcandNext;

  // The ALU adds acc+mcand every MUL cycle; only keep the sum when the multiplier bit is set.
  always_comb begin
    accNext   = mplier[0] ? alu_result : acc;
    mcandNext = mcand << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      alu_inA      <= '0;
      alu_inB      <= '0;
      alu_Ctrl     <= 3'b000;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_err      <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mulCnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_op <= 3'b011) begin
              state    <= EXEC;
              alu_inA  <= req_a;
              alu_inB  <= req_b;
              alu_Ctrl <= req_op;
            end else if (req_op == 3'b100) begin
              state    <= MUL;
              acc      <= '0;
              mcand    <= req_a;
              mplier   <= req_b;
              mulCnt   <= '0;
              alu_inA  <= '0;
              alu_inB  <= req_a;
              alu_Ctrl <= 3'b000;
            end else begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_result   <= '0;
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_cout     <= 1'b0;
              rsp_err      <= 1'b1;
            end
          end
        end
        EXEC: begin
          state        <= RESP;
          rsp_valid    <= 1'b1;
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_cout     <= alu_Cout;
          rsp_err      <= 1'b0;
          alu_inA      <= '0;
          alu_inB      <= '0;
          alu_Ctrl     <= 3'b000;
        end
        MUL: begin
          acc     <= accNext;
          mcand   <= mcandNext;
          mplier  <= mplier >> 1;
          mulCnt  <= mulCnt + CW'(1);
          alu_inA <= accNext;
          alu_inB <= mcandNext;
          if (mulCnt == CW'(WIDTH - 1)) begin
            // Flags come from the accumulated product, not from the last ALU add.
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_result   <= accNext;
            rsp_zero     <= (accNext == '0);
            rsp_overflow <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_err      <= 1'b0;
            alu_inA      <= '0;
            alu_inB      <= '0;
            alu_Ctrl     <= 3'b000;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Drives alu_sequencer with directed and random requests against a combinational ALU model and a
// reference built from plain arithmetic (a*b, signed compare, etc.).
module tb_alu_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic        err;
  } rspT;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_inA;
  logic [31:0] alu_inB;
  logic [2:0]  alu_Ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_Cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_cout;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_Ctrl(alu_Ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_Cout(alu_Cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rspT aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rspT r;
    logic [32:0] s;
    r = '0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[31:0];
        r.cout = s[32];
        r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} - {1'b0, b};
        r.res = s[31:0];
        r.cout = ~s[32];
        r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      3'b010: r.res = a ^ b;
      3'b011: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.res = 32'd0;
    endcase
    r.zero = (r.res == 32'd0);
    return r;
  endfunction

  always_comb begin
    rspT r;
    r = aluModel(alu_Ctrl, alu_inA, alu_inB);
    alu_result   = r.res;
    alu_zero     = r.zero;
    alu_overflow = r.ovf;
    alu_Cout     = r.cout;
  end

  function automatic rspT expected(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rspT r;
    r = '0;
    if (op <= 3'b011) begin
      r = aluModel(op, a, b);
    end else if (op == 3'b100) begin
      r.res = a * b;
      r.zero = (r.res == 32'd0);
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    rspT exp;
    int lat;
    int expLat;
    logic [31:0] heldRes;
    exp = expected(op, a, b);
    expLat = (op <= 3'b011) ? 1 : (op == 3'b100) ? 32 : 0;
    @(negedge clk);
    check("req_ready idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (lat == 0 && op <= 3'b011) begin
        check("exec inA", alu_inA, a);
        check("exec inB", alu_inB, b);
        check("exec ctrl", {29'b0, alu_Ctrl}, {29'b0, op});
      end else if (lat == 0 && op == 3'b100) begin
        check("mul0 inA", alu_inA, 32'd0);
        check("mul0 inB", alu_inB, a);
        check("mul ctrl", {29'b0, alu_Ctrl}, 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, expLat);
    check("rsp_result", rsp_result, exp.res);
    check("rsp_zero", {31'b0, rsp_zero}, {31'b0, exp.zero});
    check("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, exp.ovf});
    check("rsp_cout", {31'b0, rsp_cout}, {31'b0, exp.cout});
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp.err});
    check("req_ready resp", {31'b0, req_ready}, 32'd0);
    check("resp aluA", alu_inA, 32'd0);
    heldRes = rsp_result;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op = 3'($urandom);
      req_a = $urandom;
      @(negedge clk);
      check("hold valid", {31'b0, rsp_valid}, 32'd1);
      check("hold result", rsp_result, heldRes);
      check("hold err", {31'b0, rsp_err}, {31'b0, exp.err});
      check("hold req_ready", {31'b0, req_ready}, 32'd0);
      check("hold ctrl", {29'b0, alu_Ctrl}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid drop", {31'b0, rsp_valid}, 32'd0);
    check("req_ready back", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_a = 32'd0;
    req_b = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset flags", {28'b0, rsp_zero, rsp_overflow, rsp_cout, rsp_err}, 32'd0);
    check("reset alu", alu_inA | alu_inB | {29'b0, alu_Ctrl}, 32'd0);
    reset = 1'b0;

    runOp(3'b000, 32'h7FFFFFFF, 32'd1, 0);
    runOp(3'b001, 32'd5, 32'd5, 3);
    runOp(3'b100, 32'h00010001, 32'h00010001, 1);
    runOp(3'b100, 32'h80000000, 32'd2, 0);
    runOp(3'b100, 32'h12345678, 32'd0, 0);
    runOp(3'b110, 32'hDEADBEEF, 32'h1, 2);
    runOp(3'b011, 32'hFFFFFFFF, 32'd1, 0);
    runOp(3'b001, 32'h80000000, 32'd1, 0);

    // Reset mid-multiply must discard the pending product.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'b100;
    req_a = 32'hFFFFFFFF;
    req_b = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mulrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mulrst req_ready", {31'b0, req_ready}, 32'd1);
    check("mulrst alu", alu_inA | alu_inB | {29'b0, alu_Ctrl}, 32'd0);
    repeat (35) @(negedge clk);
    check("mulrst no rsp", {31'b0, rsp_valid}, 32'd0);
    runOp(3'b010, 32'hF0F0F0F0, 32'hFFFF0000, 0);
    check("xor constant", expected(3'b010, 32'hF0F0F0F0, 32'hFFFF0000).res, 32'h0F0FF0F0);

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1;
    req_op = 3'b000;
    req_a = 32'd1;
    req_b = 32'd2;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstacc req_ready", {31'b0, req_ready}, 32'd1);
    check("rstacc rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstacc alu", alu_inA | alu_inB, 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      runOp(op, a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
